// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle integer divide unit: FSM state
// encoding, div_op bit positions, iteration count and a magnitude helper.
package div_pkg;

    localparam int DIV_XLEN = 32;

    // div_op bit positions
    localparam int DIV_OP_MOD = 0;
    localparam int DIV_OP_UNS = 1;

    // One restoring step per quotient bit
    localparam logic [5:0] DIV_ITER = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Absolute value for signed operands, raw value for unsigned ones.
    // 0x80000000 maps onto itself, which the unsigned datapath reads as 2^31.
    function automatic logic [DIV_XLEN-1:0] div_mag(input logic [DIV_XLEN-1:0] v,
                                                    input logic              is_signed);
        return (is_signed && v[DIV_XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// EX <-> divide unit handshake bundle. The master (EX) issues operations,
// consumes results and drives flush; the slave is the divide unit.
interface div_if #(
    parameter int XLEN = 32
) ();

    logic            flush;
    logic            div_valid;
    logic            div_ready;
    logic [1:0]      div_op;
    logic [XLEN-1:0] div_src1;
    logic [XLEN-1:0] div_src2;
    logic [XLEN-1:0] div_result;
    logic            div_result_valid;
    logic            div_result_ready;

    modport master (
        output flush,
        output div_valid,
        output div_op,
        output div_src1,
        output div_src2,
        output div_result_ready,
        input  div_ready,
        input  div_result,
        input  div_result_valid
    );

    modport slave (
        input  flush,
        input  div_valid,
        input  div_op,
        input  div_src1,
        input  div_src2,
        input  div_result_ready,
        output div_ready,
        output div_result,
        output div_result_valid
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step on {rem, quo}. Purely combinational;
// the caller holds rem below the divisor, so the shifted value fits in
// XLEN+1 bits and a successful subtract always fits back into XLEN bits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dsr_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    // Shift in the next dividend bit, trial-subtract and restore on borrow
    always_comb begin
        rem_sh = {rem_i, quo_i[XLEN-1]};
        ge     = (rem_sh >= {1'b0, dsr_i});
        diff   = rem_sh[XLEN-1:0] - dsr_i;
        rem_o  = ge ? diff : rem_sh[XLEN-1:0];
        quo_o  = {quo_i[XLEN-2:0], ge};
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle divide unit for div.w / mod.w / div.wu / mod.wu.
// Operands are reduced to magnitudes at accept, divided unsigned over 32
// restoring steps, and signs are applied in a single fix-up cycle.
// Build option: DIV_EARLY_OUT_EN skips the iterations when the divisor is
// zero or the dividend magnitude is already below the divisor magnitude.
//
// state | meaning
// IDLE  | div_ready high, waiting for an op
// CALC  | one shift-subtract step per cycle, counter runs 32 -> 0
// FIX   | apply signs, register quotient or remainder
// DONE  | div_result_valid high, result held until consumed
module div_ctrl
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic  clk,
    input  logic  resetn,
    div_if.slave  bus
);

    div_state_e      state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            result_valid_q, result_valid_d;
    logic            ready_q, ready_d;

    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    logic            acc_signed;
    logic [XLEN-1:0] acc_mag1;
    logic [XLEN-1:0] acc_mag2;
    logic            acc_dzero;
    logic            acc_early;
    logic [XLEN-1:0] fix_quo;
    logic [XLEN-1:0] fix_rem;

    // Operand preparation at accept and sign fix-up of the finished division
    always_comb begin
        acc_signed = ~bus.div_op[DIV_OP_UNS];
        acc_mag1   = div_mag(bus.div_src1, acc_signed);
        acc_mag2   = div_mag(bus.div_src2, acc_signed);
        acc_dzero  = (bus.div_src2 == '0);
`ifdef DIV_EARLY_OUT_EN
        acc_early  = acc_dzero || (acc_mag1 < acc_mag2);
`else
        acc_early  = 1'b0;
`endif
        fix_quo    = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        fix_rem    = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Next-state and next-output logic; flush overrides accept and consume
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_d           = op_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        dsr_d          = dsr_q;
        q_neg_d        = q_neg_q;
        r_neg_d        = r_neg_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.div_valid && !bus.flush) begin
                    op_d    = bus.div_op;
                    dsr_d   = acc_mag2;
                    // A zero divisor keeps the all-ones quotient unsigned-looking;
                    // the remainder sign fix still restores the raw dividend.
                    q_neg_d = acc_signed && (bus.div_src1[XLEN-1] ^ bus.div_src2[XLEN-1])
                              && !acc_dzero;
                    r_neg_d = acc_signed && bus.div_src1[XLEN-1];
                    if (acc_early) begin
                        rem_d   = acc_mag1;
                        quo_d   = acc_dzero ? '1 : '0;
                        cnt_d   = '0;
                        state_d = ST_FIX;
                    end else begin
                        rem_d   = '0;
                        quo_d   = acc_mag1;
                        cnt_d   = DIV_ITER;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d       = op_q[DIV_OP_MOD] ? fix_rem : fix_quo;
                result_valid_d = 1'b1;
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                if (bus.div_result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d        = ST_IDLE;
            result_valid_d = 1'b0;
        end

        ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            dsr_q          <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            ready_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            dsr_q          <= dsr_d;
            q_neg_q        <= q_neg_d;
            r_neg_q        <= r_neg_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            ready_q        <= ready_d;
        end
    end

    assign bus.div_ready        = ready_q;
    assign bus.div_result       = result_q;
    assign bus.div_result_valid = result_valid_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: hand-computed quotients/remainders, latency,
// flush abort, back-pressure hold and back-to-back issue.
module tb_div_ctrl;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_MOD  = 2'd1;
    localparam logic [1:0] OP_DIVU = 2'd2;
    localparam logic [1:0] OP_MODU = 2'd3;

    localparam int LAT_FULL = 34;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SHORT = 2;
`else
    localparam int LAT_SHORT = 34;
`endif

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    div_if #(.XLEN(32)) bus ();

    div_ctrl #(.XLEN(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present an op at a negedge; returns at the negedge of cycle 1 after E0
    task automatic start(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        chk({tag, "_ready"}, 32'(bus.div_ready), 32'd1);
        bus.div_op    = op;
        bus.div_src1  = a;
        bus.div_src2  = b;
        bus.div_valid = 1'b1;
        tick();
        bus.div_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int lat, input logic [31:0] exp);
        int cyc;
        cyc = 1;
        while (!bus.div_result_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(lat));
        chk(tag, bus.div_result, exp);
    endtask

    task automatic consume(input string tag);
        bus.div_result_ready = 1'b1;
        tick();
        bus.div_result_ready = 1'b0;
        chk({tag, "_vdrop"}, 32'(bus.div_result_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(bus.div_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp);
        start(tag, op, a, b);
        wait_result(tag, lat, exp);
        consume(tag);
    endtask

    initial begin
        int          seen;
        int          bad;
        logic [31:0] held;

        checks               = 0;
        errors               = 0;
        resetn               = 1'b0;
        bus.flush            = 1'b0;
        bus.div_valid        = 1'b0;
        bus.div_op           = 2'd0;
        bus.div_src1         = '0;
        bus.div_src2         = '0;
        bus.div_result_ready = 1'b0;

        repeat (3) tick();
        chk("rst_ready", 32'(bus.div_ready), 32'd1);
        chk("rst_valid", 32'(bus.div_result_valid), 32'd0);
        chk("rst_result", bus.div_result, 32'd0);
        resetn = 1'b1;
        tick();

        run_op("div_100_7",    OP_DIV,  32'd100,       32'd7,         LAT_FULL,  32'd14);
        run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,         LAT_FULL,  32'hFFFF_FFFD);
        run_op("mod_m7_2",     OP_MOD,  32'hFFFF_FFF9, 32'd2,         LAT_FULL,  32'hFFFF_FFFF);
        run_op("mod_7_m2",     OP_MOD,  32'd7,         32'hFFFF_FFFE, LAT_FULL,  32'd1);
        run_op("divu_max_2",   OP_DIVU, 32'hFFFF_FFFF, 32'd2,         LAT_FULL,  32'h7FFF_FFFF);
        run_op("modu_max_2",   OP_MODU, 32'hFFFF_FFFF, 32'd2,         LAT_FULL,  32'd1);
        run_op("div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, LAT_FULL,  32'h8000_0000);
        run_op("mod_ovf",      OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, LAT_FULL,  32'd0);
        run_op("div_5_0",      OP_DIV,  32'd5,         32'd0,         LAT_SHORT, 32'hFFFF_FFFF);
        run_op("mod_5_0",      OP_MOD,  32'd5,         32'd0,         LAT_SHORT, 32'd5);
        run_op("divu_5_0",     OP_DIVU, 32'd5,         32'd0,         LAT_SHORT, 32'hFFFF_FFFF);
        run_op("modu_5_0",     OP_MODU, 32'd5,         32'd0,         LAT_SHORT, 32'd5);
        run_op("div_m5_0",     OP_DIV,  32'hFFFF_FFFB, 32'd0,         LAT_SHORT, 32'hFFFF_FFFF);
        run_op("mod_m5_0",     OP_MOD,  32'hFFFF_FFFB, 32'd0,         LAT_SHORT, 32'hFFFF_FFFB);
        run_op("div_m3_10",    OP_DIV,  32'hFFFF_FFFD, 32'd10,        LAT_SHORT, 32'd0);
        run_op("mod_m3_10",    OP_MOD,  32'hFFFF_FFFD, 32'd10,        LAT_SHORT, 32'hFFFF_FFFD);
        run_op("divu_1000_33", OP_DIVU, 32'd1000,      32'd33,        LAT_FULL,  32'd30);

        // Flush in cycle 10 of CALC
        start("flush", OP_DIV, 32'd100, 32'd7);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_ready", 32'(bus.div_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_result_valid) seen++;
            tick();
        end
        chk("flush_no_valid", 32'(seen), 32'd0);

        // Back-pressure hold in DONE, then consume with a new op pending
        start("hold", OP_MOD, 32'd100, 32'd7);
        wait_result("hold", LAT_FULL, 32'd2);
        held = bus.div_result;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.div_result_valid || bus.div_result !== held) bad++;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        chk("hold_value", held, 32'd2);

        bus.div_op           = OP_MODU;
        bus.div_src1         = 32'hFFFF_FFFF;
        bus.div_src2         = 32'd2;
        bus.div_valid        = 1'b1;
        bus.div_result_ready = 1'b1;
        tick();
        bus.div_result_ready = 1'b0;
        chk("b2b_vdrop", 32'(bus.div_result_valid), 32'd0);
        chk("b2b_ready", 32'(bus.div_ready), 32'd1);
        tick();
        bus.div_valid = 1'b0;
        chk("b2b_accepted", 32'(bus.div_ready), 32'd0);
        wait_result("b2b", LAT_FULL, 32'd1);
        consume("b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle integer divide unit with its own sequencing FSM. It implements LA32R `div.w`, `mod.w`, `div.wu` and `mod.wu` beside the single-cycle ALU in the EX stage. The ALU keeps add, logic, shift and multiply; division is issued here through a valid/ready handshake. EX stalls until the result has been handed back. The block also honours pipeline flush.

## Interface
- `XLEN`, default 32: operand width. Only 32 is supported.
- `clk` input 1: the single clock.
- `resetn` input 1: reset, synchronous and active-low.
- `flush` input 1: pipeline flush; aborts any operation in progress.
- `div_valid` input 1: EX presents a divide op.
- `div_ready` output 1: the unit can accept an op; high only in IDLE.
- `div_op` input 2: bit0 selects remainder (mod), bit1 selects unsigned.
- `div_src1` input XLEN: dividend.
- `div_src2` input XLEN: divisor.
- `div_result` output XLEN: quotient or remainder.
- `div_result_valid` output 1: result available.
- `div_result_ready` input 1: EX consumes the result.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Accept:** happens on the edge where `div_valid & div_ready & ~flush` holds. The unit latches `div_op`. It also latches the magnitudes of both sources: absolute values when signed, raw values when unsigned. It then clears the partial remainder, loads the 6-bit iteration counter with 32, and moves to CALC.
- **CALC:** one restoring shift-subtract step per cycle.
  - Shift `{rem, quo}` left by 1.
  - If the upper 33 bits are ≥ the divisor, subtract the divisor and set the quotient LSB.
  - Decrement the counter; move to FIX when it reaches 0.
- **FIX:** applies signs for signed ops.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - `div_result` is then registered from the quotient or remainder according to `div_op[0]`. Move to DONE.
- **DONE:** `div_result_valid` is high and `div_result` is held stable. On `div_result_ready` the unit returns to IDLE.
- **Divide by zero (signed or unsigned):** quotient = 0xFFFFFFFF, remainder = dividend unchanged, with no sign fix.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the magnitude path and needs no special case.
- **Flush:** in any state, the state is IDLE on the next cycle and `div_result_valid` drops. No result is produced. `flush` takes priority over an accept or a consume in the same cycle.
- **Reset:** state is IDLE and counter is 0. Outputs: `div_ready`=1, `div_result_valid`=0, `div_result`=0.

## Timing
- Let the accept edge be E0.
- CALC occupies cycles 1–32, FIX cycle 33, and `div_result_valid` first rises in cycle 34.
- Back-pressure is unbounded: DONE holds until `div_result_ready`.
- `div_ready` rises in the cycle after consumption. Back-to-back ops therefore cost 35 cycles each.
- `div_ready` is a function of state only. It has no combinational path from `div_valid`.
- `div_result_valid` and `div_result` are registered outputs.

## Configuration
- **`DIV_EARLY_OUT_EN` defined:**
  - At accept, if the divisor is zero, or the dividend magnitude is below the divisor magnitude, the unit skips CALC and goes directly to FIX.
  - In that case quotient = 0 (all ones for a zero divisor) and remainder = dividend magnitude.
  - `div_result_valid` rises in cycle 2 after E0.
- **Not defined:** every op takes the full 34-cycle latency, and the comparator is not built.

## Structure
- **Shared package** `div_pkg`:
  - State enum (IDLE/CALC/FIX/DONE).
  - `div_op` bit positions (`DIV_OP_MOD`=0, `DIV_OP_UNS`=1).
  - Iteration count constant (32).
- **Sub-module** `div_step`: combinational single shift-subtract step. It takes rem/quo/divisor and returns next rem/quo. It is instantiated once in `div_ctrl`.

## Test plan
1. `div.w` 100 / 7: result 14. `div_result_valid` rises exactly 34 cycles after E0 (2 cycles if the macro is defined and the shortcut fires; here it does not).
2. `div.w` −7 / 2: result 0xFFFFFFFD. `mod.w` −7 / 2: result 0xFFFFFFFF. `mod.w` 7 / −2: result 1.
3. `div.wu` 0xFFFFFFFF / 2: result 0x7FFFFFFF. `mod.wu` 0xFFFFFFFF / 2: result 1.
4. Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
5. 5 / 0 with both signed and unsigned ops: quotient 0xFFFFFFFF, remainder 5. Latency is 34 cycles without the macro and 2 cycles with `DIV_EARLY_OUT_EN`.
6. Control sequencing:
   - Assert `flush` in cycle 10 of CALC: `div_ready`=1 in the next cycle and no `div_result_valid` is ever seen.
   - Hold `div_result_ready`=0 for 20 cycles in DONE: result stays stable.
   - Then consume while a new `div_valid` is pending: the new op is accepted one cycle later.
